// File: rtl/dmem_pkg.sv
// Shared encodings, request record and access-legality check for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic [2:0] {ERR_NONE, ERR_RW, ERR_SIZE, ERR_ALIGN, ERR_RANGE} err_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign_ext;
  } req_t;

  // First failing rule wins; the code is kept so the priority stays visible.
  function automatic err_e check_access(input req_t req, input int unsigned addr_w);
    logic [31:0] hi;
    err_e        code;
    hi = req.addr >> (addr_w + 2);
    if (req.rd && req.wr) begin
      code = ERR_RW;
    end else if (req.size == SZ_RSVD) begin
      code = ERR_SIZE;
    end else if ((req.size == SZ_H && req.addr[0]) ||
                 (req.size == SZ_W && req.addr[1:0] != 2'b00)) begin
      code = ERR_ALIGN;
    end else if (hi != 32'd0) begin
      code = ERR_RANGE;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wlanes,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Store data is replicated across lanes so byte_en alone picks the target lane.
  always_comb begin
    byte_en = 4'b0000;
    wlanes  = wdata;
    case (size)
      SZ_B: begin
        byte_en = 4'b0001 << addr_lo;
        wlanes  = {4{wdata[7:0]}};
      end
      SZ_H: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{wdata[15:0]}};
      end
      SZ_W: begin
        byte_en = 4'b1111;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

  always_comb begin
    shifted   = rword >> {addr_lo, 3'b000};
    load_data = rword;
    case (size)
      SZ_B:    load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_data = rword;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a CPU load/store, waits LATENCY cycles, then commits the
// access to a word-organised array and returns a one-cycle registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam logic [3:0]  CntInit = 4'(LATENCY);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_live, req_cur;
  logic              accept;
  logic              enter_resp;
  logic              access_ok;
  logic              mem_we;
  err_e              err_code;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rword;
  logic [31:0]       load_data;
  logic [31:0]       wlanes;
  logic [3:0]        byte_en;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              err_q;

  logic [31:0] mem [DEPTH];

  assign req_live = '{rd: DM_R, wr: DM_W, addr: addr, wdata: wdata, size: size,
                      sign_ext: sign_ext};
  assign accept   = (state_q == IDLE) && (DM_R || DM_W);
  // With LATENCY=0 the commit edge is also the accept edge, so use the live request there.
  assign req_cur  = (state_q == IDLE) ? req_live : req_q;
  assign word_idx = req_cur.addr[ADDR_W+1:2];
  assign rword    = mem[word_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enter_resp = (state_d == RESP);
    err_code   = check_access(req_cur, ADDR_W);
    access_ok  = (err_code == ERR_NONE);
    mem_we     = enter_resp && access_ok && req_cur.wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= req_live;
    end
  end

  dmem_align u_align (
    .addr_lo   (req_cur.addr[1:0]),
    .size      (req_cur.size),
    .sign_ext  (req_cur.sign_ext),
    .wdata     (req_cur.wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wlanes    (wlanes),
    .load_data (load_data)
  );

  // Array is never cleared; reset only blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= enter_resp;
      err_q   <= enter_resp && !access_ok;
      rdata_q <= (enter_resp && access_ok && req_cur.rd) ? load_data : 32'd0;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random bench for dmem_responder at LATENCY 1, 0 and 15 behind one shared CPU port.
module tb_dmem_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dm_r, dm_w;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        sign_ext;
  int unsigned sel;

  logic [2:0]  r_g, w_g;
  logic [31:0] rdata_v [3];
  logic [2:0]  ready_v, err_v;
  logic [31:0] rdata_o;
  logic        ready_o, err_o;

  int   n_cmp;
  int   n_fail;
  exp_t sb[$];
  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      r_g[i] = dm_r && (sel == i);
      w_g[i] = dm_w && (sel == i);
    end
    rdata_o = rdata_v[sel % 3];
    ready_o = ready_v[sel % 3];
    err_o   = err_v[sel % 3];
  end

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .DM_R(r_g[0]), .DM_W(w_g[0]), .addr(addr), .wdata(wdata),
    .size(size), .sign_ext(sign_ext), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .DM_R(r_g[1]), .DM_W(w_g[1]), .addr(addr), .wdata(wdata),
    .size(size), .sign_ext(sign_ext), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .DM_R(r_g[2]), .DM_W(w_g[2]), .addr(addr), .wdata(wdata),
    .size(size), .sign_ext(sign_ext), .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of the 1024-word instance, byte addressed, little-endian lanes.
  task automatic model_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                              output logic e, output logic [31:0] d);
    logic [11:0] i;
    logic [31:0] v;
    e = (r && w) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
        (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd4096);
    d = 32'd0;
    i = a[11:0];
    if (!e && w) begin
      ref_mem[i] = wd[7:0];
      if (sz != 2'b00) ref_mem[i + 12'd1] = wd[15:8];
      if (sz == 2'b10) begin
        ref_mem[i + 12'd2] = wd[23:16];
        ref_mem[i + 12'd3] = wd[31:24];
      end
    end else if (!e) begin
      if (sz == 2'b00) begin
        v = {24'd0, ref_mem[i]};
        d = (sx && v[7]) ? (v | 32'hFFFF_FF00) : v;
      end else if (sz == 2'b01) begin
        v = {16'd0, ref_mem[i + 12'd1], ref_mem[i]};
        d = (sx && v[15]) ? (v | 32'hFFFF_0000) : v;
      end else begin
        d = {ref_mem[i + 12'd3], ref_mem[i + 12'd2], ref_mem[i + 12'd1], ref_mem[i]};
      end
    end
  endtask

  // One complete access on the selected instance; exp_lat < 0 skips the latency check.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                        input bit use_exp, input logic [31:0] exp_d, input logic exp_e,
                        input int exp_lat, input string tag);
    exp_t        x;
    int          n;
    logic        me;
    logic [31:0] md;
    me = 1'b0;
    md = 32'd0;
    if (sel == 0) model_access(r, w, a, wd, sz, sx, me, md);
    x.err   = use_exp ? exp_e : me;
    x.rdata = use_exp ? exp_d : md;
    sb.push_back(x);
    @(negedge clk);
    dm_r = r; dm_w = w; addr = a; wdata = wd; size = sz; sign_ext = sx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 40);
    dm_r = 1'b0;
    dm_w = 1'b0;
    x = sb.pop_front();
    check({tag, " ready"}, {31'd0, ready_o}, 32'd1);
    if (ready_o) begin
      check({tag, " rdata"}, rdata_o, x.rdata);
      check({tag, " err"}, {31'd0, err_o}, {31'd0, x.err});
      if (exp_lat >= 0) check({tag, " latency"}, 32'(n), 32'(exp_lat));
    end
  endtask

  // Hold a read across several responses and measure the spacing between ready pulses.
  task automatic held_gap(input logic [31:0] a, input logic [31:0] exp_d, input int exp_gap,
                          input string tag);
    int n;
    @(negedge clk);
    dm_r = 1'b1; dm_w = 1'b0; addr = a; size = 2'b10; sign_ext = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 40);
    check({tag, " first ready"}, {31'd0, ready_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ready_o && n < 40);
      check({tag, " gap"}, 32'(n), 32'(exp_gap));
      check({tag, " rdata"}, rdata_o, exp_d);
    end
    dm_r = 1'b0;
  endtask

  // Aborted store: reset arrives wait_cycles after the request is driven.
  task automatic aborted_store(input logic [31:0] a, input int wait_cycles,
                               input int watch, input string tag);
    int pulses;
    @(negedge clk);
    dm_r = 1'b0; dm_w = 1'b1; addr = a; wdata = 32'h1234_5678; size = 2'b10; sign_ext = 1'b0;
    repeat (wait_cycles) @(negedge clk);
    reset = 1'b1;
    dm_w  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check({tag, " ready after reset"}, {31'd0, ready_o}, 32'd0);
    check({tag, " err after reset"}, {31'd0, err_o}, 32'd0);
    check({tag, " rdata after reset"}, rdata_o, 32'd0);
    pulses = 0;
    repeat (watch) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    check({tag, " stray ready"}, 32'(pulses), 32'd0);
  endtask

  logic        e_r  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] e_a  [6] = '{32'h11, 32'h12, 32'h1000, 32'h10, 32'h10, 32'h13};
  logic [1:0]  e_sz [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
  logic [31:0] f_a  [6] = '{32'h10, 32'h10, 32'h0, 32'h10, 32'h10, 32'h10};
  logic [31:0] f_d  [6] = '{32'hDEAD5AEF, 32'hDEAD5AEF, 32'h0BADF00D, 32'hDEAD5AEF,
                            32'hDEAD5AEF, 32'hDEAD5AEF};

  initial begin
    logic        rr, ww, sx;
    logic [1:0]  sz;
    logic [31:0] a;
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    dm_r = 1'b0; dm_w = 1'b0; addr = 32'd0; wdata = 32'd0; size = 2'b00; sign_ext = 1'b0;
    sel = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset ready", {31'd0, ready_o}, 32'd0);
      check("reset err", {31'd0, err_o}, 32'd0);
      check("reset rdata", rdata_o, 32'd0);
    end
    sel = 0;

    // Word store/load and lane accesses, LATENCY=1.
    access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 1, 32'h0, 0, 2, "sw 0x10");
    access(1, 0, 32'h10, 32'h0, 2'b10, 0, 1, 32'hDEADBEEF, 0, 2, "lw 0x10");
    access(0, 1, 32'h11, 32'hFFFF_FF5A, 2'b00, 0, 1, 32'h0, 0, 2, "sb 0x11");
    access(1, 0, 32'h10, 32'h0, 2'b10, 1, 1, 32'hDEAD5AEF, 0, 2, "lw after sb");
    access(1, 0, 32'h13, 32'h0, 2'b00, 1, 1, 32'hFFFFFFDE, 0, 2, "lb 0x13");
    access(1, 0, 32'h13, 32'h0, 2'b00, 0, 1, 32'h000000DE, 0, 2, "lbu 0x13");
    access(1, 0, 32'h12, 32'h0, 2'b01, 1, 1, 32'hFFFFDEAD, 0, 2, "lh 0x12");
    access(1, 0, 32'h10, 32'h0, 2'b01, 0, 1, 32'h00005AEF, 0, 2, "lhu 0x10");
    access(0, 1, 32'h0, 32'h0BADF00D, 2'b10, 0, 1, 32'h0, 0, 2, "sw 0x0");

    // Rejected accesses leave the targeted word untouched.
    for (int k = 0; k < 6; k++) begin
      access(e_r[k], 1, e_a[k], 32'hFFFF_FFFF, e_sz[k], 1, 1, 32'h0, 1, 2, "error access");
      access(1, 0, f_a[k], 32'h0, 2'b10, 0, 1, f_d[k], 0, 2, "error follow-up");
    end

    // Reset landing on the commit edge suppresses the store.
    access(0, 1, 32'h20, 32'hCAFEF00D, 2'b10, 0, 1, 32'h0, 0, 2, "sw 0x20");
    aborted_store(32'h20, 1, 6, "commit-edge reset");
    access(1, 0, 32'h20, 32'h0, 2'b10, 0, 1, 32'hCAFEF00D, 0, 2, "0x20 after commit reset");
    held_gap(32'h10, 32'hDEAD5AEF, 3, "held L1");

    // LATENCY=0 instance.
    sel = 1;
    access(0, 1, 32'h4, 32'h11223344, 2'b10, 0, 1, 32'h0, 0, 1, "L0 sw");
    access(1, 0, 32'h4, 32'h0, 2'b10, 0, 1, 32'h11223344, 0, 1, "L0 lw");
    access(1, 0, 32'h100, 32'h0, 2'b10, 0, 1, 32'h0, 1, 1, "L0 range");
    held_gap(32'h4, 32'h11223344, 2, "held L0");

    // LATENCY=15 instance, including a reset in the middle of WAIT.
    sel = 2;
    access(0, 1, 32'h20, 32'hA5A5A5A5, 2'b10, 0, 1, 32'h0, 0, 16, "L15 sw");
    access(1, 0, 32'h20, 32'h0, 2'b10, 0, 1, 32'hA5A5A5A5, 0, 16, "L15 lw");
    aborted_store(32'h20, 6, 25, "mid-wait reset");
    access(1, 0, 32'h20, 32'h0, 2'b10, 0, 1, 32'hA5A5A5A5, 0, 16, "0x20 after wait reset");

    // Random mix against the byte model on the LATENCY=1 instance.
    sel = 0;
    for (int i = 0; i < 64; i++) begin
      access(0, 1, 32'(i * 4), $urandom, 2'b10, 0, 0, 32'h0, 0, 2, "rand init");
    end
    for (int i = 0; i < 10000; i++) begin
      rr = 1'($urandom_range(0, 1));
      ww = !rr;
      if ($urandom_range(0, 31) == 0) begin
        rr = 1'b1;
        ww = 1'b1;
      end
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      sx = 1'($urandom_range(0, 1));
      access(rr, ww, a, $urandom, sz, sx, 0, 32'h0, 0, 2, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
